// File: rtl/com_uart.sv
// COM serial-port responder: 8N1 transmitter and receiver with read-ready/write-ready
// status, sticky overrun/framing flags and an edge-detected read acknowledge.
module com_uart #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((DIV / 2) - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_e;

  tx_state_e         tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_baud_q, tx_baud_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              txd_q, txd_d;
  logic              tx_ready_q, tx_ready_d;

  logic              rx_meta_q, rx_sync_q;
  rx_state_e         rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_baud_q, rx_baud_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_done_s, rx_bad_stop_s;

  logic              rx_ack_q;
  logic              ack_rise_s, rx_load_s, rx_drop_s;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_ready_q, rx_ready_d;
  logic              rx_ovr_q, rx_ovr_d;
  logic              rx_ferr_q, rx_ferr_d;

  // TX next-state: the byte is latched only in IDLE, so strobes while busy fall through.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_ready_d = tx_ready_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) begin
          tx_shift_d = tx_data;
          tx_baud_d  = CNT_ZERO;
          tx_bit_d   = 3'd0;
          txd_d      = 1'b0;
          tx_ready_d = 1'b0;
          tx_state_d = TX_START;
        end else begin
          txd_d      = 1'b1;
          tx_ready_d = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = CNT_ZERO;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_baud_d  = tx_baud_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = CNT_ZERO;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_baud_d = tx_baud_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = CNT_ZERO;
          txd_d      = 1'b1;
          tx_ready_d = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_baud_d  = tx_baud_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_baud_d  = CNT_ZERO;
        tx_bit_d   = 3'd0;
        txd_d      = 1'b1;
        tx_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= CNT_ZERO;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // Two-flop synchronizer; loads idle-high so reset never fakes a start bit.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rxd;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_baud_d     = rx_baud_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_done_s     = 1'b0;
    rx_bad_stop_s = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_baud_d  = CNT_ZERO;
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d = CNT_ZERO;
          rx_bit_d  = 3'd0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_baud_d = rx_baud_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = CNT_ZERO;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d   = rx_bit_q + 3'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d = CNT_ZERO;
          if (rx_sync_q) begin
            rx_done_s  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_bad_stop_s = 1'b1;
            rx_state_d    = RX_WAIT_IDLE;
          end
        end else begin
          rx_baud_d = rx_baud_q + CNT_ONE;
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_sync_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_WAIT_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_baud_d  = CNT_ZERO;
        rx_bit_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= CNT_ZERO;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // An ack rising in the completion cycle frees the slot, so the new byte loads cleanly.
  always_comb begin
    ack_rise_s = rx_ack & ~rx_ack_q;
    rx_load_s  = rx_done_s & (~rx_ready_q | ack_rise_s);
    rx_drop_s  = rx_done_s & rx_ready_q & ~ack_rise_s;
    if (rx_load_s) begin
      rx_data_d  = rx_shift_q;
      rx_ready_d = 1'b1;
    end else if (ack_rise_s) begin
      rx_data_d  = rx_data_q;
      rx_ready_d = 1'b0;
    end else begin
      rx_data_d  = rx_data_q;
      rx_ready_d = rx_ready_q;
    end
    if (rx_drop_s) begin
      rx_ovr_d = 1'b1;
    end else if (ack_rise_s) begin
      rx_ovr_d = 1'b0;
    end else begin
      rx_ovr_d = rx_ovr_q;
    end
    if (rx_bad_stop_s) begin
      rx_ferr_d = 1'b1;
    end else if (ack_rise_s) begin
      rx_ferr_d = 1'b0;
    end else begin
      rx_ferr_d = rx_ferr_q;
    end
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      rx_ack_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_ready_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_ack_q   <= rx_ack;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign uart_txd     = txd_q;
  assign tx_ready     = tx_ready_q;
  assign rx_data      = rx_data_q;
  assign rx_ready     = rx_ready_q;
  assign rx_overrun   = rx_ovr_q;
  assign rx_frame_err = rx_ferr_q;

endmodule

// File: tb/tb_com_uart.sv
// Self-checking bench for com_uart at DIV=16: table-driven TX/RX vectors with a
// scoreboard queue, plus hand-written glitch and mid-frame reset sequences.
module tb_com_uart;
  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DIV      = 16;

  logic       clk50M = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ack;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       uart_txd;
  logic       uart_rxd;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       busy_poke;
    logic       chain;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_rdy;
    logic [7:0] exp_data;
    logic       exp_ovr;
    logic       exp_ferr;
    int         ack_len;
  } rx_vec_t;

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       ovr;
    logic       ferr;
  } rx_exp_t;

  logic [9:0] tx_q[$];
  rx_exp_t    rx_q[$];
  tx_vec_t    tv[3];
  rx_vec_t    rv[4];

  always #5 clk50M = ~clk50M;

  com_uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk50M       (clk50M),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_ack       (rx_ack),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .uart_txd     (uart_txd),
    .uart_rxd     (uart_rxd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; strobes the byte, then checks mid-bit levels and ready timing.
  task automatic run_tx(input logic [7:0] d, input logic [9:0] frame, input logic busy_poke,
                        input logic chain);
    logic [9:0] exp;
    tx_data  = d;
    tx_start = 1'b1;
    tx_q.push_back(frame);
    @(negedge clk50M);
    tx_start = 1'b0;
    tx_data  = ~d;
    exp = tx_q.pop_front();
    for (int cyc = 1; cyc <= 161; cyc++) begin
      if (cyc > 1) @(negedge clk50M);
      if (cyc == 50 && busy_poke) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
      end
      if (cyc == 51) tx_start = 1'b0;
      if (cyc % DIV == DIV / 2) chk("tx_bit", uart_txd, exp[cyc / DIV]);
      if (cyc == 1 || cyc == 80 || cyc == 160) chk("tx_ready_busy", tx_ready, 1'b0);
      if (cyc == 161) begin
        chk("tx_ready_done", tx_ready, 1'b1);
        chk("tx_idle_level", uart_txd, 1'b1);
      end
    end
    if (!chain) begin
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk50M);
        if (k % 8 == 0) begin
          chk("tx_no_extra_frame", uart_txd, 1'b1);
          chk("tx_ready_idle", tx_ready, 1'b1);
        end
      end
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      uart_rxd = bits[b];
      repeat (DIV) @(negedge clk50M);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic check_rx_exp();
    rx_exp_t e;
    if (rx_q.size() == 0) begin
      chk("rx_scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = rx_q.pop_front();
      chk("rx_ready", rx_ready, e.rdy);
      chk("rx_data", rx_data, e.data);
      chk("rx_overrun", rx_overrun, e.ovr);
      chk("rx_frame_err", rx_frame_err, e.ferr);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_start = 1'b0;
    rx_ack   = 1'b0;
    uart_rxd = 1'b1;

    tv[0] = '{8'hA5, 10'b1_10100101_0, 1'b1, 1'b0};
    tv[1] = '{8'h00, 10'b1_00000000_0, 1'b0, 1'b1};
    tv[2] = '{8'h3C, 10'b1_00111100_0, 1'b0, 1'b0};

    rv[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 5};
    rv[1] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 0};
    rv[2] = '{8'h22, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1};
    rv[3] = '{8'h5A, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1};

    repeat (3) @(negedge clk50M);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_ready", rx_ready, 1'b0);
    chk("rst_rx_overrun", rx_overrun, 1'b0);
    chk("rst_rx_frame_err", rx_frame_err, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk50M);

    for (int i = 0; i < 3; i++) begin
      run_tx(tv[i].data, tv[i].frame, tv[i].busy_poke, tv[i].chain);
    end

    for (int i = 0; i < 4; i++) begin
      rx_q.push_back('{rv[i].exp_rdy, rv[i].exp_data, rv[i].exp_ovr, rv[i].exp_ferr});
      send_rx(rv[i].data, rv[i].stop_bit);
      repeat (2) @(negedge clk50M);
      check_rx_exp();
      if (rv[i].ack_len > 0) begin
        rx_ack = 1'b1;
        @(negedge clk50M);
        chk("ack_clears_ready", rx_ready, 1'b0);
        chk("ack_clears_overrun", rx_overrun, 1'b0);
        chk("ack_clears_frame_err", rx_frame_err, 1'b0);
        repeat (rv[i].ack_len - 1) @(negedge clk50M);
        rx_ack = 1'b0;
        @(negedge clk50M);
        chk("ack_held_ready", rx_ready, 1'b0);
        chk("rx_data_after_ack", rx_data, rv[i].exp_data);
      end
      repeat (20) @(negedge clk50M);
    end

    // Short low glitch on an idle line must be rejected without flags.
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk50M);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk50M);
    chk("glitch_rx_ready", rx_ready, 1'b0);
    chk("glitch_overrun", rx_overrun, 1'b0);
    chk("glitch_frame_err", rx_frame_err, 1'b0);
    chk("glitch_rx_data", rx_data, 8'h11);
    rx_q.push_back('{1'b1, 8'h96, 1'b0, 1'b0});
    send_rx(8'h96, 1'b1);
    repeat (2) @(negedge clk50M);
    check_rx_exp();

    // Reset asserted between clock edges in the middle of a TX frame.
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    @(negedge clk50M);
    tx_start = 1'b0;
    repeat (39) @(negedge clk50M);
    chk("pre_rst_txd_low", uart_txd, 1'b0);
    chk("pre_rst_busy", tx_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_txd", uart_txd, 1'b1);
    chk("async_rst_tx_ready", tx_ready, 1'b1);
    chk("async_rst_rx_ready", rx_ready, 1'b0);
    chk("async_rst_rx_data", rx_data, 8'h00);
    @(negedge clk50M);
    rst = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk50M);
      if (k % 16 == 0) begin
        chk("post_rst_tx_ready", tx_ready, 1'b1);
        chk("post_rst_txd", uart_txd, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/com_uart.md
Name: com_uart

Overview:
- Serial-port responder behind the physical memory controller's COM data/status addresses (0x1FD003F8 / 0x1FD003FC).
- Accepts one-cycle write strobes carrying a byte and transmits it as 8N1 on the board UART TX pin.
- Receives 8N1 frames on the RX pin and presents the byte plus read-ready/write-ready status for the controller's status word.
- Clears read-ready on the controller's read acknowledge.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_FREQ/BAUD, integer-truncated; 434 at defaults. DIV must be ≥ 4.

Ports:
- clk50M  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tx_data  in  8  byte to send; sampled only in the cycle tx_start is high.
- tx_start  in  1  one-cycle write strobe, driven by enable_com_write.
- tx_ready  out  1  transmitter idle; drives com_write_ready.
- rx_data  out  8  last received byte; drives com_data_in.
- rx_ready  out  1  unread byte available; drives com_read_ready.
- rx_ack  in  1  read acknowledge, driven by int_com_ack; may stay high for many cycles.
- rx_overrun  out  1  sticky flag: a byte was dropped because rx_ready was still set.
- rx_frame_err  out  1  sticky flag: a stop bit was sampled low.
- uart_txd  out  1  serial output; idles high.
- uart_rxd  in  1  serial input; asynchronous to clk50M.

Behaviour:

Reset:
- Asynchronous assert; all outputs take their reset values immediately.
- Reset values: uart_txd=1, tx_ready=1, rx_data=0, rx_ready=0, rx_overrun=0, rx_frame_err=0.
- Both FSMs go to IDLE, all counters clear, and the RX synchronizer flops load 1.
- Reset mid-frame aborts that frame with no partial output.

TX FSM (IDLE, START, DATA, STOP); one shared bit counter, one baud counter 0..DIV-1:
- IDLE: tx_start=1 latches tx_data. Next cycle: tx_ready=0, uart_txd=0, go to START.
- tx_start while tx_ready=0 is ignored; the latched byte is unaffected.
- START: hold low for DIV cycles, then go to DATA.
- DATA: 8 bits, LSB first, DIV cycles each, then go to STOP.
- STOP: hold high for DIV cycles, then go to IDLE with tx_ready=1.
- tx_ready returns high exactly 10*DIV+1 cycles after the tx_start edge.
- A tx_start in that same cycle starts the next frame back-to-back, with no extra idle bit.

RX path:
- uart_rxd passes through a 2-flop synchronizer (rxs).
- IDLE: rxs=0 starts the baud counter; go to START.
- START: after DIV/2 cycles (integer), resample rxs.
  - rxs=1 is a glitch: return to IDLE with no flags set.
  - rxs=0: go to DATA.
- DATA: sample every DIV cycles; 8 samples shifted in LSB first.
- STOP: sample once after DIV cycles.
  - Sample high: byte is complete.
  - Sample low: discard the byte, set rx_frame_err, go to WAIT_IDLE. WAIT_IDLE stays until rxs=1, then returns to IDLE.
- Completion moves to IDLE in the same cycle, so a start bit can be detected in the next cycle.

Receive handshake:
- ack_rise = rx_ack & ~rx_ack_q, where rx_ack_q is rx_ack registered.
- ack_rise clears rx_ready, rx_overrun and rx_frame_err in the next cycle.
- A held-high rx_ack has no further effect.
- Byte complete and rx_ready=0: rx_data loaded and rx_ready=1 in the next cycle.
- Byte complete, rx_ready=1, no ack_rise in the same cycle: new byte dropped, rx_data unchanged, rx_overrun=1.
- Byte complete in the same cycle as ack_rise: new byte loaded, rx_ready stays 1, rx_overrun not set.
- rx_data holds its value after being acked.
- TX and RX are fully independent; simultaneous activity has no interaction.

Test Plan:
- All tests use CLK_FREQ=16, BAUD=1, so DIV=16.
- Reset check: assert rst mid-TX frame → uart_txd=1 and tx_ready=1 immediately; after release, tx_ready stays 1.
- TX 0xA5: one-cycle tx_start → uart_txd reads 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; tx_ready=0 throughout; tx_ready=1 at cycle 161.
- TX busy: a second tx_start with 0xFF during frame 1 → frame 1 bits unchanged, no second frame.
- RX 0x3C: drive 8N1 0x3C at 16 cycles/bit → rx_ready=1 and rx_data=0x3C; rx_ack held high 5 cycles → rx_ready=0 one cycle after the rise, rx_data still 0x3C.
- RX overrun: send 0x11 then 0x22 with no ack → rx_data=0x11, rx_overrun=1; rx_ack pulse → rx_ready=0, rx_overrun=0.
- RX error cases, run separately:
  - Stop bit low → rx_ready=0, rx_frame_err=1.
  - 4-cycle low glitch on idle line → no state change, no flags.
